// File: rtl/ft245_bus_arbiter.sv
// Half-duplex sequencer owning the FT245 pins: arbitrates RX/TX and times RD#, WR# and bus drive.
// Optional: define FT245_ARB_RX_PRIORITY_EN to give RX strict priority over TX.
module ft245_bus_arbiter #(
  parameter int RD_PULSE_CYC    = 3,
  parameter int RD_INACTIVE_CYC = 2,
  parameter int WR_SETUP_CYC    = 1,
  parameter int WR_PULSE_CYC    = 3,
  parameter int WR_HOLD_CYC     = 1,
  parameter int WR_INACTIVE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_245,
  input  logic       rxf_245,
  output logic       rx_245,
  output logic [7:0] tx_data_245,
  input  logic       txe_245,
  output logic       tx_245,
  output logic       tx_oe_245,
  output logic [7:0] rx_data_si,
  output logic       rx_rdy_si,
  input  logic       rx_ack_si,
  input  logic [7:0] tx_data_si,
  input  logic       tx_rdy_si,
  output logic       tx_ack_si,
  output logic       busy,
  output logic [2:0] dbg_state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(RD_PULSE_CYC, RD_INACTIVE_CYC),
                                     max2(WR_SETUP_CYC, WR_PULSE_CYC)),
                                max2(WR_HOLD_CYC, WR_INACTIVE_CYC));
  localparam int CW = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RD_PULSE    = 3'd1,
    ST_RD_INACTIVE = 3'd2,
    ST_WR_SETUP    = 3'd3,
    ST_WR_PULSE    = 3'd4,
    ST_WR_HOLD     = 3'd5,
    ST_WR_INACTIVE = 3'd6
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last_tx, last_tx_d;
  logic          rx_245_d, tx_245_d, tx_oe_d, tx_ack_d, rx_rdy_d;
  logic [7:0]    tx_data_d, rx_data_d;
  logic          rx_req, tx_req, grant_rx, grant_tx;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last_tx     <= 1'b1;
      rx_245      <= 1'b1;
      tx_245      <= 1'b1;
      tx_oe_245   <= 1'b0;
      tx_data_245 <= 8'h00;
      rx_data_si  <= 8'h00;
      rx_rdy_si   <= 1'b0;
      tx_ack_si   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      last_tx     <= last_tx_d;
      rx_245      <= rx_245_d;
      tx_245      <= tx_245_d;
      tx_oe_245   <= tx_oe_d;
      tx_data_245 <= tx_data_d;
      rx_data_si  <= rx_data_d;
      rx_rdy_si   <= rx_rdy_d;
      tx_ack_si   <= tx_ack_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CW'(1);
    last_tx_d = last_tx;
    rx_245_d  = rx_245;
    tx_245_d  = tx_245;
    tx_oe_d   = tx_oe_245;
    tx_data_d = tx_data_245;
    rx_data_d = rx_data_si;
    tx_ack_d  = 1'b0;
    // An ack drops the held byte unless a capture below overrides it.
    rx_rdy_d  = rx_rdy_si & ~rx_ack_si;
    rx_req    = ~rxf_245 & (~rx_rdy_si | rx_ack_si);
    tx_req    = ~txe_245 & tx_rdy_si;
    grant_rx  = 1'b0;
    grant_tx  = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef FT245_ARB_RX_PRIORITY_EN
        grant_rx = rx_req;
        grant_tx = tx_req & ~rx_req;
`else
        if (rx_req && tx_req) begin
          grant_rx = last_tx;
          grant_tx = ~last_tx;
        end else begin
          grant_rx = rx_req;
          grant_tx = tx_req;
        end
`endif
        if (grant_rx) begin
          rx_245_d  = 1'b0;
          last_tx_d = 1'b0;
          state_d   = ST_RD_PULSE;
        end else if (grant_tx) begin
          tx_data_d = tx_data_si;
          tx_oe_d   = 1'b1;
          tx_ack_d  = 1'b1;
          last_tx_d = 1'b1;
          state_d   = ST_WR_SETUP;
        end
      end
      ST_RD_PULSE: begin
        if (cnt == CW'(RD_PULSE_CYC - 1)) begin
          rx_data_d = rx_data_245;
          rx_rdy_d  = 1'b1;
          rx_245_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RD_INACTIVE;
        end
      end
      ST_RD_INACTIVE: begin
        if (cnt == CW'(RD_INACTIVE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WR_SETUP: begin
        if (cnt == CW'(WR_SETUP_CYC - 1)) begin
          tx_245_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_WR_PULSE;
        end
      end
      ST_WR_PULSE: begin
        if (cnt == CW'(WR_PULSE_CYC - 1)) begin
          tx_245_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: begin
        if (cnt == CW'(WR_HOLD_CYC - 1)) begin
          tx_oe_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_WR_INACTIVE;
        end
      end
      ST_WR_INACTIVE: begin
        if (cnt == CW'(WR_INACTIVE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        rx_245_d = 1'b1;
        tx_245_d = 1'b1;
        tx_oe_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ft245_bus_arbiter.sv
// Bench for ft245_bus_arbiter: FT245 device and fabric models, transaction-timeline reference and byte scoreboards.
module tb_ft245_bus_arbiter;

  localparam int RDP = 3, RDI = 2, WS = 1, WP = 3, WH = 1, WI = 2;
  localparam int RTOT = RDP + RDI;
  localparam int WTOT = WS + WP + WH + WI;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data_245 = 8'hEE;
  logic       rxf_245 = 1'b1;
  logic       rx_245;
  logic [7:0] tx_data_245;
  logic       txe_245 = 1'b1;
  logic       tx_245;
  logic       tx_oe_245;
  logic [7:0] rx_data_si;
  logic       rx_rdy_si;
  logic       rx_ack_si = 1'b0;
  logic [7:0] tx_data_si = 8'h00;
  logic       tx_rdy_si = 1'b0;
  logic       tx_ack_si;
  logic       busy;
  logic [2:0] dbg_state;

  ft245_bus_arbiter #(
    .RD_PULSE_CYC(RDP), .RD_INACTIVE_CYC(RDI), .WR_SETUP_CYC(WS),
    .WR_PULSE_CYC(WP), .WR_HOLD_CYC(WH), .WR_INACTIVE_CYC(WI)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data_245(rx_data_245), .rxf_245(rxf_245), .rx_245(rx_245),
    .tx_data_245(tx_data_245), .txe_245(txe_245), .tx_245(tx_245), .tx_oe_245(tx_oe_245),
    .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(rx_ack_si),
    .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] dev_q[$];
  logic [7:0] src_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic       grant_q[$];

  int   ack_mode = 0;
  logic rxf_mask = 1'b0, rxf_hold = 1'b0, txe_mask = 1'b1, tx_gap = 1'b0;
  logic drv_prev_rx = 1'b1;

  // Reference: cycles elapsed since the current grant (-1 = idle) plus buffered byte state.
  int         m_k = -1;
  logic       m_dir_tx = 1'b0, m_last_tx = 1'b1, m_rdy = 1'b0, m_init = 1'b0;
  logic [7:0] m_rx_data = 8'h00, m_tx_data = 8'h00;
  logic       prev_rx = 1'b1, prev_tx = 1'b1, prev_rst = 1'b1;
  logic [5:0] exp_ctl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic model_step();
    logic rq, tq, g_rx, g_tx;
    if (rst) begin
      m_k = -1; m_last_tx = 1'b1; m_rdy = 1'b0;
      m_rx_data = 8'h00; m_tx_data = 8'h00; m_init = 1'b1;
    end else begin
      rq = !rxf_245 && (!m_rdy || rx_ack_si);
      tq = !txe_245 && tx_rdy_si;
      if (rx_ack_si) m_rdy = 1'b0;
      if (m_k < 0) begin
`ifdef FT245_ARB_RX_PRIORITY_EN
        g_rx = rq;
        g_tx = tq && !rq;
`else
        if (rq && tq) begin
          g_rx = m_last_tx;
          g_tx = !m_last_tx;
        end else begin
          g_rx = rq;
          g_tx = tq;
        end
`endif
        if (g_rx) begin
          m_k = 0; m_dir_tx = 1'b0; m_last_tx = 1'b0;
        end else if (g_tx) begin
          m_k = 0; m_dir_tx = 1'b1; m_last_tx = 1'b1; m_tx_data = tx_data_si;
        end
      end else begin
        m_k++;
        if (!m_dir_tx && m_k == RDP) begin
          m_rdy = 1'b1;
          m_rx_data = rx_data_245;
        end
        if (m_k == (m_dir_tx ? WTOT : RTOT)) m_k = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      exp_ctl = {!(!m_dir_tx && m_k >= 0 && m_k < RDP),
                 !(m_dir_tx && m_k >= WS && m_k < WS + WP),
                 (m_dir_tx && m_k >= 0 && m_k < WS + WP + WH),
                 (m_dir_tx && m_k == 0),
                 (m_k >= 0),
                 m_rdy};
      check("ctl{rd,wr,oe,ack,busy,rdy}", 32'({rx_245, tx_245, tx_oe_245, tx_ack_si, busy, rx_rdy_si}),
            32'(exp_ctl));
      check("data{rx_si,tx_245}", 32'({rx_data_si, tx_data_245}), 32'({m_rx_data, m_tx_data}));
      check("inv_rd_and_wr_low", 32'(!rx_245 && !tx_245), 32'(0));
      check("inv_oe_during_rd", 32'(!rx_245 && tx_oe_245), 32'(0));
      check("inv_wr_without_oe", 32'(!tx_245 && !tx_oe_245), 32'(0));
      if (!prev_rst) begin
        if (prev_rx && !rx_245) grant_q.push_back(1'b0);
        if (tx_ack_si) grant_q.push_back(1'b1);
        if (!prev_tx && tx_245) begin
          if (exp_tx.size() == 0) fail_now("tx_byte_unexpected");
          else check("tx_byte", 32'(tx_data_245), 32'(exp_tx.pop_front()));
        end
      end
      if (!rst && rx_rdy_si && rx_ack_si) begin
        if (exp_rx.size() == 0) fail_now("rx_byte_unexpected");
        else check("rx_byte", 32'(rx_data_si), 32'(exp_rx.pop_front()));
      end
    end
    prev_rx  = rx_245;
    prev_tx  = tx_245;
    prev_rst = rst;
    model_step();
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rst) begin
      if (!drv_prev_rx && rx_245 && dev_q.size() > 0) dev_q.delete(0);
      if (tx_ack_si && src_q.size() > 0) src_q.delete(0);
    end
    drv_prev_rx = rx_245;
    case (ack_mode)
      0:       rx_ack_si = 1'b0;
      1:       rx_ack_si = rx_rdy_si;
      default: rx_ack_si = ($urandom_range(0, 3) == 0);
    endcase
    rxf_245     = (dev_q.size() == 0) || rxf_mask || rxf_hold;
    rx_data_245 = (dev_q.size() > 0) ? dev_q[0] : 8'hEE;
    txe_245     = txe_mask;
    tx_rdy_si   = (src_q.size() > 0) && !tx_gap;
    tx_data_si  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic dev_push(input logic [7:0] b);
    dev_q.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic src_push(input logic [7:0] b);
    src_q.push_back(b);
    exp_tx.push_back(b);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    dev_q.delete(); src_q.delete(); exp_rx.delete(); exp_tx.delete();
    run(n);
    rst = 1'b0;
  endtask

  task automatic drain(input int bound);
    int i;
    ack_mode = 1; rxf_mask = 1'b0; rxf_hold = 1'b0; txe_mask = 1'b0; tx_gap = 1'b0;
    i = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0 || m_k >= 0) && i < bound) begin
      cycle();
      i++;
    end
    if (i >= bound) fail_now("drain_timeout");
  endtask

  function automatic int count_dir(input logic dir);
    int c = 0;
    foreach (grant_q[j]) if (grant_q[j] == dir) c++;
    return c;
  endfunction

  initial begin
    int i;
    logic exp_g[4];
    do_reset(3);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_state", 32'(dbg_state), 32'(0));

    // Single read, then a second byte waits for the ack.
    grant_q.delete();
    txe_mask = 1'b1; ack_mode = 0;
    dev_push(8'hA5); dev_push(8'h11);
    run(30);
    check("reads_before_ack", 32'(count_dir(1'b0)), 32'(1));
    check("rx_data_held", 32'(rx_data_si), 32'(8'hA5));
    check("rx_rdy_held", 32'(rx_rdy_si), 32'(1));
    drain(100);

    // Single write.
    src_push(8'h3C);
    txe_mask = 1'b0;
    run(20);
    drain(50);

    // Contested arbitration.
    grant_q.delete();
    for (int b = 0; b < 6; b++) begin
      dev_push(8'(8'h40 + b));
      src_push(8'(8'hC0 + b));
    end
    drain(600);
`ifdef FT245_ARB_RX_PRIORITY_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    if (grant_q.size() < 4) fail_now("contest_grant_count");
    else for (int g = 0; g < 4; g++) check("contest_grant_dir", 32'(grant_q[g]), 32'(exp_g[g]));

    // Unacked RX byte blocks reads, writes proceed.
    ack_mode = 0;
    dev_push(8'h77);
    i = 0;
    while (!rx_rdy_si && i < 40) begin cycle(); i++; end
    if (i >= 40) fail_now("rx_rdy_timeout");
    grant_q.delete();
    dev_push(8'h78);
    src_push(8'h90); src_push(8'h91); src_push(8'h92);
    run(60);
    check("blocked_reads", 32'(count_dir(1'b0)), 32'(0));
    check("blocked_writes", 32'(count_dir(1'b1)), 32'(3));
    drain(100);

    // Reset in the middle of the WR# pulse.
    src_push(8'h5E);
    txe_mask = 1'b0;
    i = 0;
    while (tx_245 && i < 40) begin cycle(); i++; end
    if (i >= 40) fail_now("wr_pulse_timeout");
    grant_q.delete();
    do_reset(1);
    check("rst_wr_high", 32'(tx_245), 32'(1));
    check("rst_oe_low", 32'(tx_oe_245), 32'(0));
    check("rst_state_idle", 32'(dbg_state), 32'(0));
    run(10);
    check("rst_no_more_ack", 32'(count_dir(1'b1)), 32'(0));

    // RXF# deasserted during the RD# pulse.
    dev_push(8'h5A);
    ack_mode = 0;
    i = 0;
    while (rx_245 && i < 40) begin cycle(); i++; end
    if (i >= 40) fail_now("rd_pulse_timeout");
    rxf_hold = 1'b1;
    run(8);
    check("rxf_drop_rdy", 32'(rx_rdy_si), 32'(1));
    check("rxf_drop_data", 32'(rx_data_si), 32'(8'h5A));
    drain(60);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) ack_mode = $urandom_range(1, 2);
      if (dev_q.size() < 8 && $urandom_range(0, 5) == 0) dev_push(8'($urandom));
      if (src_q.size() < 8 && $urandom_range(0, 5) == 0) src_push(8'($urandom));
      txe_mask = ($urandom_range(0, 3) == 0);
      rxf_mask = ($urandom_range(0, 4) == 0);
      tx_gap   = ($urandom_range(0, 5) == 0);
      cycle();
    end
    drain(2000);
    check("rx_scoreboard_empty", 32'(exp_rx.size()), 32'(0));
    check("tx_scoreboard_empty", 32'(exp_tx.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ft245_bus_arbiter.md
Name: ft245_bus_arbiter

Overview:
Half-duplex sequencer for the shared FT245 parallel bus. It arbitrates between the host-to-FPGA read path and the FPGA-to-host write path, and drives RD#, WR# and the data-bus output enable with counted pulse, setup and recovery timing. Toward the fabric it exposes one simple RX interface and one simple TX interface. It is the single owner of the FT245 pins; no other block drives RD#, WR# or the bus.

Parameters:
RD_PULSE_CYC, 3, cycles RD# held low before data is sampled (≥1)
RD_INACTIVE_CYC, 2, cycles RD# held high after a read before the next arbitration (≥1)
WR_SETUP_CYC, 1, cycles data is driven with WR# high before WR# falls (≥1)
WR_PULSE_CYC, 3, cycles WR# held low (≥1)
WR_HOLD_CYC, 1, cycles data stays driven after WR# rises (≥1)
WR_INACTIVE_CYC, 2, cycles the bus is released before the next arbitration (≥1)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
rx_data_245  in  8  FT245 data bus, input side
rxf_245  in  1  FT245 RXF#, low = byte available
rx_245  out  1  FT245 RD#, active low
tx_data_245  out  8  FT245 data bus, output side
txe_245  in  1  FT245 TXE#, low = space available
tx_245  out  1  FT245 WR#, active low
tx_oe_245  out  1  bus output enable, 1 = FPGA drives the bus
rx_data_si  out  8  received byte
rx_rdy_si  out  1  rx_data_si valid; held until acknowledged
rx_ack_si  in  1  one-cycle consume strobe; ignored unless rx_rdy_si=1
tx_data_si  in  8  byte to send
tx_rdy_si  in  1  tx_data_si valid
tx_ack_si  out  1  one-cycle pulse: byte captured, source may advance
busy  out  1  1 whenever state ≠ ST_IDLE

Behaviour:
- Reset values: rx_245=1, tx_245=1, tx_oe_245=0, tx_data_245=0, rx_data_si=0, rx_rdy_si=0, tx_ack_si=0, busy=0, state=ST_IDLE, cnt=0, last_dir=TX (so RX wins the first contested arbitration).
- Reset mid-transfer: strobes return high and the bus is released on the next edge. Any byte being read is discarded; rx_rdy_si is cleared.
- Request terms:
  - rx_req = (rxf_245==0) && (rx_rdy_si==0 or rx_ack_si==1 this cycle)
  - tx_req = (txe_245==0) && (tx_rdy_si==1)
- ST_IDLE: with no request, stay. With exactly one request, serve it. With both, serve the direction opposite last_dir (round-robin), then update last_dir. Serving RX: rx_245←0, cnt←0, go to ST_RD_PULSE. Serving TX: tx_data_245←tx_data_si, tx_oe_245←1, tx_ack_si←1 for exactly one cycle, cnt←0, go to ST_WR_SETUP.
- ST_RD_PULSE: cnt increments. When cnt==RD_PULSE_CYC-1: rx_data_si←rx_data_245, rx_rdy_si←1, rx_245←1, cnt←0, go to ST_RD_INACTIVE.
- ST_RD_INACTIVE: count RD_INACTIVE_CYC cycles, then go to ST_IDLE.
- ST_WR_SETUP: after WR_SETUP_CYC cycles, tx_245←0 and go to ST_WR_PULSE.
- ST_WR_PULSE: after WR_PULSE_CYC cycles, tx_245←1 and go to ST_WR_HOLD.
- ST_WR_HOLD: after WR_HOLD_CYC cycles, tx_oe_245←0 and go to ST_WR_INACTIVE. tx_data_245 holds its value.
- ST_WR_INACTIVE: after WR_INACTIVE_CYC cycles, go to ST_IDLE.
- Bus invariants: rx_245 and tx_245 are never low in the same cycle. tx_oe_245=0 whenever rx_245=0. tx_245=0 only while tx_oe_245=1.
- Read latency: RD# low for exactly RD_PULSE_CYC cycles. rx_rdy_si rises on the same edge RD# rises.
- RX buffering:
  - rx_ack_si clears rx_rdy_si on the next edge.
  - If an ack and a new capture land on the same edge, the capture wins and rx_rdy_si stays 1 with the new data.
  - While rx_rdy_si=1 and no ack, RX is never granted; TX continues unaffected.
- Flag changes: rxf_245 or txe_245 deasserting mid-transfer does not abort it. Flags are evaluated only in ST_IDLE.
- Counter: single shared cnt, width $clog2 of the largest *_CYC parameter plus 1, reset to 0 on every state entry.
- Unknown state: recover to ST_IDLE with all strobes high and tx_oe_245=0.

Optional Feature:
FT245_ARB_RX_PRIORITY_EN
- Defined: when both requests are pending in ST_IDLE, RX always wins. last_dir is not used. TX is served only when rx_req=0.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- After rst: rxf=0, txe=1, byte 0xA5 on the bus → RD# low exactly 3 cycles; rx_data_si=0xA5, rx_rdy_si=1 on the RD# rising edge; a second read does not start until rx_ack_si is pulsed.
- tx_rdy_si=1 with 0x3C, txe=0 → tx_ack_si pulses once; tx_oe=1 for 1+3+1 cycles; WR# low 3 cycles with tx_data_245=0x3C throughout; bus released, then 2 idle cycles.
- rxf=0 and txe=0 held, tx_rdy_si=1, rx_ack_si pulsed each time rx_rdy_si rises → grants alternate RX,TX,RX,TX starting with RX. With FT245_ARB_RX_PRIORITY_EN, all grants are RX.
- rx_rdy_si=1 (unacked), rxf=0, tx pending → only writes occur. Pulse rx_ack_si in ST_IDLE → the read is granted that same cycle.
- rst asserted mid WR_PULSE → next edge: tx_245=1, tx_oe_245=0, state ST_IDLE, no further tx_ack_si.
- rxf_245 deasserted during RD_PULSE → read still completes after 3 cycles and data is captured. Checker flags any cycle with RD#=0 and WR#=0.
